alarm_ctrl: RTL

- Central sequencer of the alarm clock. Consumes the one-second pulse from the clock divider and keeps hh:mm:ss time.
- Holds the alarm setpoint and runs the user-mode FSM: run, set time, set alarm, ringing.
- Drives the display/ringer outputs. Sits between the divider, the debounced button pulses and the display decoder.

---
 rtl/alarm_pkg.sv | 63 ++++++
 rtl/alarm_ctrl_hms_counter.sv | 61 ++++++
 rtl/alarm_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types, widths and wrap helpers for the alarm clock sequencer.
// Used by hms_counter and alarm_ctrl (optional snooze: ALARM_SNOOZE_EN).
package alarm_pkg;

   localparam int HR_W  = 5;
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;

   localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      SET_TIME  = 2'd1,
      SET_ALARM = 2'd2,
      RINGING   = 2'd3
   } mode_e;

   typedef enum logic {
      F_HOURS   = 1'b0,
      F_MINUTES = 1'b1
   } field_e;

   typedef struct packed {
      logic [HR_W-1:0]  hours;
      logic [MIN_W-1:0] minutes;
   } hm_t;

   localparam hm_t ALM_RST = '{hours: 5'd7, minutes: 6'd0};

   // Modulo-24 increment.
   function automatic logic [HR_W-1:0] hr_inc(
      input logic [HR_W-1:0] v
   );
      return (v == HR_MAX) ? '0 : v + 5'd1;
   endfunction

   // Modulo-60 increment, shared by minutes and seconds.
   function automatic logic [MIN_W-1:0] sx_inc(
      input logic [MIN_W-1:0] v
   );
      return (v == MIN_MAX) ? '0 : v + 6'd1;
   endfunction

   // hh:mm plus dm minutes (dm <= 59), wrapping past 23:59.
   function automatic hm_t hm_add(
      input hm_t             t,
      input logic [MIN_W-1:0] dm
   );
      logic [MIN_W:0] s;
      hm_t            r;
      s = {1'b0, t.minutes} + {1'b0, dm};
      r = t;
      if (s > {1'b0, MIN_MAX}) begin
         r.minutes = MIN_W'(s - 7'd60);
         r.hours   = hr_inc(t.hours);
      end else begin
         r.minutes = s[MIN_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/alarm_ctrl_hms_counter.sv
// hh:mm:ss time registers: tick advance with carry chain, freeze, seconds
// clear and per-field increment without carry. Ports: clk, rstn, i_tick,
// i_freeze, i_clr_sec, i_inc_hr, i_inc_min in; o_hours/o_minutes/o_seconds
// state, o_nxt (hh:mm after this tick), o_roll (tick lands on ss==0) out.
module hms_counter
   import alarm_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_tick,
   input  logic             i_freeze,
   input  logic             i_clr_sec,
   input  logic             i_inc_hr,
   input  logic             i_inc_min,
   output logic [HR_W-1:0]  o_hours,
   output logic [MIN_W-1:0] o_minutes,
   output logic [SEC_W-1:0] o_seconds,
   output hm_t              o_nxt,
   output logic             o_roll
);

   logic [HR_W-1:0]  r_hr;
   logic [MIN_W-1:0] r_min;
   logic [SEC_W-1:0] r_sec;

   logic w_adv;
   logic w_sec_wrap;
   logic w_min_wrap;
   hm_t  w_nxt;

   assign w_adv      = i_tick & ~i_freeze;
   assign w_sec_wrap = (r_sec == MIN_MAX);
   assign w_min_wrap = w_sec_wrap & (r_min == MIN_MAX);

   assign w_nxt.minutes = w_sec_wrap ? sx_inc(r_min) : r_min;
   assign w_nxt.hours   = w_min_wrap ? hr_inc(r_hr) : r_hr;

   assign o_nxt     = w_nxt;
   assign o_roll    = w_adv & w_sec_wrap;
   assign o_hours   = r_hr;
   assign o_minutes = r_min;
   assign o_seconds = r_sec;

   // Edits only arrive while frozen, so they never collide with a tick.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_hr  <= '0;
         r_min <= '0;
         r_sec <= '0;
      end else if (w_adv) begin
         r_sec <= sx_inc(r_sec);
         r_min <= w_nxt.minutes;
         r_hr  <= w_nxt.hours;
      end else begin
         if (i_clr_sec) r_sec <= '0;
         if (i_inc_hr)  r_hr  <= hr_inc(r_hr);
         if (i_inc_min) r_min <= sx_inc(r_min);
      end
   end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock sequencer: timekeeping, alarm setpoint, mode FSM, ringer.
// Ports: clk, rstn, tick_sec, btn_* pulses in; time, alarm, mode,
// edit_field, armed, ring out. Macro ALARM_SNOOZE_EN adds btn_snooze.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SECS  = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             tick_sec,
   input  logic             btn_mode,
   input  logic             btn_next,
   input  logic             btn_inc,
   input  logic             btn_arm,
   input  logic             btn_stop,
`ifdef ALARM_SNOOZE_EN
   input  logic             btn_snooze,
`endif
   output logic [HR_W-1:0]  hours,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic [HR_W-1:0]  alm_hours,
   output logic [MIN_W-1:0] alm_minutes,
   output logic [1:0]       mode,
   output logic             edit_field,
   output logic             armed,
   output logic             ring
);

   if (RING_SECS < 1 || RING_SECS > 255 ||
       SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_param
      $error("alarm_ctrl: parameter out of range");
   end

   mode_e      r_mode;
   field_e     r_edit;
   logic       r_armed;
   logic       r_ring;
   logic [7:0] r_cnt;
   hm_t        r_alm;

   hm_t        w_nxt;
   logic       w_roll;
   logic       w_snz_in;
   logic       w_snz_hit;
   logic       w_hi;
   logic       w_p_mode;
   logic       w_p_next;
   logic       w_p_inc;
   logic       w_p_arm;
   logic       w_trig;
   logic       w_set_t;
   logic       w_set_a;
   logic [7:0] w_cnt_nxt;
   logic       w_timeout;

   // Button arbitration: stop > snooze > mode > next > inc > arm.
   // Only the winner acts; the rest are dropped this cycle.
   assign w_hi     = btn_stop | w_snz_in;
   assign w_p_mode = btn_mode & ~w_hi;
   assign w_p_next = btn_next & ~w_hi & ~btn_mode;
   assign w_p_inc  = btn_inc & ~(w_hi | btn_mode | btn_next);
   assign w_p_arm  = btn_arm &
                     ~(w_hi | btn_mode | btn_next | btn_inc);

   assign w_set_t = (r_mode == SET_TIME);
   assign w_set_a = (r_mode == SET_ALARM);

   hms_counter u_hms (
      .clk       (clk),
      .rstn      (rstn),
      .i_tick    (tick_sec),
      .i_freeze  (w_set_t),
      .i_clr_sec (w_set_t & w_p_mode),
      .i_inc_hr  (w_set_t & w_p_inc & (r_edit == F_HOURS)),
      .i_inc_min (w_set_t & w_p_inc & (r_edit == F_MINUTES)),
      .o_hours   (hours),
      .o_minutes (minutes),
      .o_seconds (seconds),
      .o_nxt     (w_nxt),
      .o_roll    (w_roll)
   );

   // Match is judged on the post-tick time, so only a running tick
   // (never an edit) can fire the alarm.
   assign w_trig = (r_mode == RUN) & w_roll &
                   ((r_armed & (w_nxt == r_alm)) | w_snz_hit);

   assign w_cnt_nxt = r_cnt + 8'd1;
   assign w_timeout = (w_cnt_nxt == 8'(RING_SECS));

`ifdef ALARM_SNOOZE_EN
   logic r_pend;
   hm_t  r_snz;

   assign w_snz_in  = btn_snooze;
   assign w_snz_hit = r_pend & (w_nxt == r_snz);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_pend <= 1'b0;
         r_snz  <= '0;
      end else if (r_mode == RINGING && !btn_stop && btn_snooze) begin
         r_pend <= 1'b1;
         r_snz  <= hm_add('{hours: hours, minutes: minutes},
                          MIN_W'(SNOOZE_MIN));
      end else if (w_trig || (r_mode == RUN && w_p_mode) ||
                   (r_mode == RINGING && btn_stop)) begin
         r_pend <= 1'b0;
      end
   end
`else
   assign w_snz_in  = 1'b0;
   assign w_snz_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_mode  <= RUN;
         r_edit  <= F_HOURS;
         r_armed <= 1'b0;
         r_ring  <= 1'b0;
         r_cnt   <= '0;
         r_alm   <= ALM_RST;
      end else begin
         unique case (r_mode)
            RUN: begin
               if (w_trig) begin
                  r_mode <= RINGING;
                  r_ring <= 1'b1;
                  r_cnt  <= '0;
               end else if (w_p_mode) begin
                  r_mode <= SET_TIME;
                  r_edit <= F_HOURS;
               end else if (w_p_arm) begin
                  r_armed <= ~r_armed;
               end
            end
            SET_TIME: begin
               if (w_p_mode) begin
                  r_mode <= SET_ALARM;
                  r_edit <= F_HOURS;
               end else if (w_p_next) begin
                  r_edit <= (r_edit == F_HOURS) ? F_MINUTES : F_HOURS;
               end
            end
            SET_ALARM: begin
               if (w_p_mode) begin
                  r_mode <= RUN;
               end else if (w_p_next) begin
                  r_edit <= (r_edit == F_HOURS) ? F_MINUTES : F_HOURS;
               end else if (w_p_inc && w_set_a) begin
                  if (r_edit == F_HOURS)
                     r_alm.hours <= hr_inc(r_alm.hours);
                  else
                     r_alm.minutes <= sx_inc(r_alm.minutes);
               end
            end
            RINGING: begin
               if (w_hi) begin
                  r_mode <= RUN;
                  r_ring <= 1'b0;
               end else if (tick_sec) begin
                  r_cnt <= w_cnt_nxt;
                  if (w_timeout) begin
                     r_mode <= RUN;
                     r_ring <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign alm_hours   = r_alm.hours;
   assign alm_minutes = r_alm.minutes;
   assign mode        = r_mode;
   assign edit_field  = r_edit;
   assign armed       = r_armed;
   assign ring        = r_ring;

endmodule
